// File: rtl/unflatten_stream.sv
// unflatten_stream
//   Rebuilds a 2D feature map from a flattened, row-major pixel stream.
//   Pixels arrive one per cycle over a valid/ready handshake. They are
//   written into a register buffer at [row][col]. Once a frame is complete,
//   the whole map is presented downstream and held until map_ack.
//   A frame whose length disagrees with in_last raises a one-cycle frame_err.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data / in_last valid
//   in_ready   block accepts a pixel this cycle (state based only)
//   in_data    flattened pixel, flat index row*MAP_SIZE+col
//   in_last    producer marks the final pixel of a frame
//   map_out    rebuilt map, map_out[r][c] = flat[r*MAP_SIZE+c]
//   map_valid  map_out holds a complete frame
//   map_ack    consumer has taken map_out
//   frame_err  one-cycle pulse, frame length mismatch
//   pix_count  pixels written in the current frame
module unflatten_stream #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int MAP_SIZE    = 3,
  localparam int PIXEL_COUNT = MAP_SIZE * MAP_SIZE,
  localparam int CNT_W       = $clog2(PIXEL_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] map_out [0:MAP_SIZE-1][0:MAP_SIZE-1],
  output logic                  map_valid,
  input  logic                  map_ack,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      pix_count
);

  localparam int IDX_W = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAP_SIZE - 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  ready_en_q, ready_en_d;
  logic [IDX_W-1:0]      row_q, row_d;
  logic [IDX_W-1:0]      col_q, col_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] map_q [0:MAP_SIZE-1][0:MAP_SIZE-1];
  logic [DATA_WIDTH-1:0] map_d [0:MAP_SIZE-1][0:MAP_SIZE-1];

  logic xfer;
  logic at_end;

  // ready_en_q holds in_ready low through reset and for the first edge after
  // release, so in_ready depends on registered state only.
  assign in_ready  = ready_en_q && (state_q == ST_FILL);
  assign xfer      = in_valid && in_ready;
  assign at_end    = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign map_valid = (state_q == ST_FULL);
  assign frame_err = err_q;
  assign pix_count = cnt_q;
  assign map_out   = map_q;

  always_comb begin
    state_d    = state_q;
    ready_en_d = 1'b1;
    row_d      = row_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    for (int unsigned r = 0; r < MAP_SIZE; r++) begin
      for (int unsigned c = 0; c < MAP_SIZE; c++) begin
        map_d[r][c] = map_q[r][c];
      end
    end

    case (state_q)
      ST_FILL: begin
        if (xfer) begin
          map_d[row_q][col_q] = in_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (at_end || in_last) begin
            // Frame closes on the last slot or on in_last, whichever comes
            // first; a mismatch between the two is a length error.
            state_d = ST_FULL;
            row_d   = '0;
            col_d   = '0;
            err_d   = at_end ^ in_last;
          end else if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (map_ack) begin
          state_d = ST_FILL;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          // Clear on hand-off so a later short frame leaves zeros behind.
          for (int unsigned r = 0; r < MAP_SIZE; r++) begin
            for (int unsigned c = 0; c < MAP_SIZE; c++) begin
              map_d[r][c] = '0;
            end
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      ready_en_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      for (int unsigned r = 0; r < MAP_SIZE; r++) begin
        for (int unsigned c = 0; c < MAP_SIZE; c++) begin
          map_q[r][c] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      ready_en_q <= ready_en_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      for (int unsigned r = 0; r < MAP_SIZE; r++) begin
        for (int unsigned c = 0; c < MAP_SIZE; c++) begin
          map_q[r][c] <= map_d[r][c];
        end
      end
    end
  end

endmodule
